// File: rtl/read_enable_to_valid_ready.sv
// read_enable_to_valid_ready: drains a fall-through buffer into a valid/ready stream through a 2-entry skid stage
module read_enable_to_valid_ready #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             empty,
   input  logic [WIDTH-1:0] read_data,
   output logic             read_enable,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   input  logic             ready,
   output logic [1:0]       level
);
   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d, skid_q, skid_d;
   logic pop, take;
   assign read_enable = !reset && !empty && state_q != FULL;
   assign pop = read_enable;
   assign valid = state_q != EMPTY;
   assign take = valid && ready;
   assign data = data_q;
   assign level = state_q;
   always_comb begin
      state_d = state_q;
      data_d = data_q;
      skid_d = skid_q;
      case (state_q)
         EMPTY: begin
            state_d = pop ? HALF : EMPTY;
            data_d = pop ? read_data : data_q;
         end
         HALF: begin
            state_d = pop ? (take ? HALF : FULL) : (take ? EMPTY : HALF);
            data_d = pop && take ? read_data : data_q;
            skid_d = pop && !take ? read_data : skid_q;
         end
         FULL: begin
            state_d = take ? HALF : FULL;
            data_d = take ? skid_q : data_q;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= EMPTY;
         data_q <= '0;
         skid_q <= '0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
         skid_q <= skid_d;
      end
   end
endmodule
